// File: rtl/tile_sequencer.sv
// Command-level sequencer: queues matrix commands and issues one tile op per (row, col, k) step.
// Optional performance counters are built when TILE_SEQ_PERF_CNT_EN is defined.
module tile_sequencer #(
  parameter int SYS_ARR_DIM     = 16,
  parameter int MAX_MAT_WH      = 128,
  parameter int ADDR_WIDTH      = 8,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2,
  localparam int TW             = $clog2(MAX_MAT_WH / SYS_ARR_DIM)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [TW-1:0]         cmd_m_tiles,
  input  logic [TW-1:0]         cmd_k_tiles,
  input  logic [TW-1:0]         cmd_n_tiles,
  input  logic [ADDR_WIDTH-1:0] cmd_in_base,
  input  logic [ADDR_WIDTH-1:0] cmd_w_base,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic [TW-1:0]         tile_row,
  output logic [TW-1:0]         tile_col,
  output logic [TW-1:0]         tile_k,
  output logic [ADDR_WIDTH-1:0] tile_in_addr,
  output logic [ADDR_WIDTH-1:0] tile_w_addr,
  output logic                  tile_accum_clear,
  output logic                  tile_relu_en,
  output logic                  tile_last,
  input  logic                  tile_done,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  err
`ifdef TILE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int XW = ADDR_WIDTH + 2 * TW;

  localparam logic [1:0]    OP_MATMUL      = 2'd1;
  localparam logic [1:0]    OP_MATMUL_RELU = 2'd2;
  localparam logic [1:0]    OP_RESERVED    = 2'd3;
  localparam logic [CW-1:0] Q_FULL_COUNT   = CW'(CMD_DEPTH);
  localparam logic [OW-1:0] OUT_LIMIT      = OW'(MAX_OUTSTANDING);
  localparam logic [XW-1:0] DIM_X          = XW'(SYS_ARR_DIM);

  typedef struct packed {
    logic [1:0]            opcode;
    logic [TW-1:0]         m;
    logic [TW-1:0]         k;
    logic [TW-1:0]         n;
    logic [ADDR_WIDTH-1:0] in_base;
    logic [ADDR_WIDTH-1:0] w_base;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t        state, state_next;
  cmd_t          queue_mem [CMD_DEPTH];
  cmd_t          head, incoming, cur;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full, push, pop, hs, last_tile, done_ok;
  logic [TW-1:0] row, col, kk;
  logic [OW-1:0] outstanding;
  logic [XW-1:0] in_sum, w_sum;

  assign incoming = '{opcode: cmd_opcode, m: cmd_m_tiles, k: cmd_k_tiles, n: cmd_n_tiles,
                      in_base: cmd_in_base, w_base: cmd_w_base};
  assign head      = queue_mem[rd_ptr];
  assign q_empty   = (q_count == '0);
  assign q_full    = (q_count == Q_FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign hs        = tile_valid && tile_ready;
  assign last_tile = (row == cur.m) && (col == cur.n) && (kk == cur.k);
  assign done_ok   = tile_done && (outstanding != '0);

  // Command queue
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= incoming;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          if (head.opcode == OP_MATMUL || head.opcode == OP_MATMUL_RELU) state_next = S_ISSUE;
          else                                                          state_next = S_FIN;
        end
      end
      S_ISSUE: if (hs && last_tile)       state_next = S_DRAIN;
      S_DRAIN: if (outstanding == '0)     state_next = S_FIN;
      S_FIN:                              state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  // FSM outputs and tile fields
  always_comb begin
    pop              = (state == S_IDLE) && !q_empty;
    cmd_ready        = !q_full || pop;
    tile_valid       = (state == S_ISSUE) && (outstanding < OUT_LIMIT);
    cmd_done         = (state == S_FIN);
    busy             = !q_empty || (state != S_IDLE);
    tile_accum_clear = (state == S_ISSUE) && (kk == '0);
    tile_relu_en     = (state == S_ISSUE) && (kk == cur.k) && (cur.opcode == OP_MATMUL_RELU);
    tile_last        = (state == S_ISSUE) && last_tile;
    tile_row         = row;
    tile_col         = col;
    tile_k           = kk;
    // Widened so the row/k products never overflow before the final wrap to ADDR_WIDTH.
    in_sum = XW'(cur.in_base) + (XW'(row) * (XW'(cur.k) + XW'(1)) + XW'(kk)) * DIM_X;
    w_sum  = XW'(cur.w_base)  + (XW'(kk)  * (XW'(cur.n) + XW'(1)) + XW'(col)) * DIM_X;
    tile_in_addr = ADDR_WIDTH'(in_sum);
    tile_w_addr  = ADDR_WIDTH'(w_sum);
  end

  // Working command, tile walk and outstanding tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= '0;
      row         <= '0;
      col         <= '0;
      kk          <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (pop) begin
        cur <= head;
        row <= '0;
        col <= '0;
        kk  <= '0;
        if (head.opcode == OP_RESERVED) err <= 1'b1;
      end else if (hs) begin
        if (kk != cur.k) begin
          kk <= kk + 1'b1;
        end else begin
          kk <= '0;
          if (col != cur.n) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            row <= row + 1'b1;
          end
        end
      end
      case ({hs, done_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (tile_done && outstanding == '0) err <= 1'b1;
    end
  end

`ifdef TILE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (tile_valid && !tile_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif

endmodule
